// File: rtl/apb_slave_mux_n_if.sv
// ---------------------------------------------------------------------------
// apb_slave_mux_n_if
// Bundles the bus signals around the APB slave fan-out stage: the bridge
// facing side (PSEL/PENABLE/PADDR in, PREADY/PRDATA/PSLVERR out), the
// per-slave side (PSEL_S out, PREADY_S/PRDATA_S/PSLVERR_S in) and the
// watchdog event pulse TIMEOUT_EVT.
//   slave  modport : view of the fan-out stage itself
//   master modport : view of whatever drives it (bridge plus slave models)
// ---------------------------------------------------------------------------
interface apb_slave_mux_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                             PSEL;
    logic                             PENABLE;
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic [NUM_SLAVES-1:0]            PSEL_S;
    logic [NUM_SLAVES-1:0]            PREADY_S;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_S;
    logic [NUM_SLAVES-1:0]            PSLVERR_S;
    logic                             PREADY;
    logic [DATA_WIDTH-1:0]            PRDATA;
    logic                             PSLVERR;
    logic                             TIMEOUT_EVT;

    modport slave (
        input  PSEL, PENABLE, PADDR, PREADY_S, PRDATA_S, PSLVERR_S,
        output PSEL_S, PREADY, PRDATA, PSLVERR, TIMEOUT_EVT
    );

    modport master (
        output PSEL, PENABLE, PADDR, PREADY_S, PRDATA_S, PSLVERR_S,
        input  PSEL_S, PREADY, PRDATA, PSLVERR, TIMEOUT_EVT
    );
endinterface

// File: rtl/apb_slave_mux_n.sv
// ---------------------------------------------------------------------------
// apb_slave_mux_n
// APB fan-out between one bridge-side PSEL and NUM_SLAVES peripherals.
// The slave index is the top SEL_BITS of PADDR; PSEL is routed to that slave
// and its PREADY/PRDATA/PSLVERR are returned combinationally. Unmapped
// indices complete immediately with PSLVERR, and a per-transfer watchdog
// forces an error completion when a slave holds PREADY low too long.
// Ports:
//   PCLK    : clock, all state on rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : apb_slave_mux_n_if.slave (bridge side, slave side, TIMEOUT_EVT)
// ---------------------------------------------------------------------------
module apb_slave_mux_n #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_slave_mux_n_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO   = CNT_W'(TIMEOUT);
    localparam logic [SEL_BITS:0] NUM_S = (SEL_BITS + 1)'(NUM_SLAVES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state, state_nxt;
    logic [SEL_BITS-1:0]  idx, lat_idx;
    logic                 unmapped, lat_unmapped;
    logic [CNT_W-1:0]     wdog;
    logic                 timeout_evt_q;

    logic                 sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                 forced;
    logic                 start;
    logic                 unused_addr;

    // Only the top SEL_BITS of the address matter here; the rest belongs to
    // the slaves.
    assign unused_addr = ^bus.PADDR;

    // The extra MSB lets the unmapped compare work when NUM_SLAVES equals
    // 2**SEL_BITS (every index mapped).
    assign idx      = bus.PADDR[ADDR_WIDTH-1 -: SEL_BITS];
    assign unmapped = ({1'b0, idx} >= NUM_S);
    assign start    = bus.PSEL && !bus.PENABLE;

    // Response of the latched slave, selected by compare rather than by a
    // dynamic index so an out-of-range lat_idx just yields zeros.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (lat_idx == SEL_BITS'(i)) begin
                sel_ready = bus.PREADY_S[i];
                sel_err   = bus.PSLVERR_S[i];
                sel_data  = bus.PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A slave answering in the saturation cycle beats the watchdog.
    assign forced = (state == ACCESS) && !lat_unmapped && (wdog == TMO) && !sel_ready;

    // Next state, slave selects and bridge response.
    always_comb begin
        state_nxt   = state;
        bus.PSEL_S  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    bus.PSEL_S[i] = bus.PSEL && (idx == SEL_BITS'(i)) && !unmapped;
                end
                if (start) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    bus.PSEL_S[i] = bus.PSEL && (lat_idx == SEL_BITS'(i)) && !lat_unmapped;
                end
                if (lat_unmapped || forced) begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = 1'b1;
                end else begin
                    bus.PREADY  = sel_ready;
                    bus.PSLVERR = sel_err;
                    bus.PRDATA  = sel_data;
                end
                // A dropped PSEL is a bridge abort and takes priority.
                if (!bus.PSEL || bus.PREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer tracking: latch the decode at setup, run the watchdog while
    // the latched slave is stalling, and pulse the event after a forced end.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lat_idx       <= '0;
            lat_unmapped  <= 1'b0;
            wdog          <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            timeout_evt_q <= forced && bus.PSEL;
            if (state == IDLE) begin
                if (start) begin
                    lat_idx      <= idx;
                    lat_unmapped <= unmapped;
                end
                wdog <= '0;
            end else if (state_nxt == IDLE) begin
                wdog <= '0;
            end else if (!lat_unmapped && !sel_ready && (wdog < TMO)) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    assign bus.TIMEOUT_EVT = timeout_evt_q;

endmodule
